// File: rtl/pwm_duty_ramper.sv
// pwm_duty_ramper: slew-rate limits the duty driven to the PWM peripheral toward the SPI target
module pwm_duty_ramper #(
    parameter int DUTY_W = 8,
    parameter int STEP_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              hold,
    output logic [DUTY_W-1:0] duty_out,
    output logic              ramping,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic              done_q, done_d;
    logic              ramping_q, ramping_d;
    logic [DUTY_W:0]   step_ext, up_sum, dn_lim;
    logic [DUTY_W-1:0] up_next, dn_next;
    logic              tick;

    // Candidate step results, clamped at the target so they never overshoot, wrap or underflow
    always_comb begin
        step_ext = (DUTY_W + 1)'(step);
        up_sum   = {1'b0, duty_q} + step_ext;
        dn_lim   = {1'b0, target_duty} + step_ext;
        up_next  = (up_sum >= {1'b0, target_duty}) ? target_duty : up_sum[DUTY_W-1:0];
        dn_next  = ({1'b0, duty_q} <= dn_lim) ? target_duty : duty_q - DUTY_W'(step);
        tick     = presc_q >= rate_div;
    end

    // Next-state: hold freezes everything, step==0 bypasses, otherwise ramp one tick at a time
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (hold) begin
            state_d = state_q;
        end else if (step == '0) begin
            duty_d  = target_duty;
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (target_duty > duty_q) begin
                        state_d = UP;
                        presc_d = '0;
                    end else if (target_duty < duty_q) begin
                        state_d = DOWN;
                        presc_d = '0;
                    end
                end
                UP: begin
                    if (target_duty == duty_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (target_duty < duty_q) begin
                        state_d = DOWN;
                        presc_d = '0;
                    end else if (tick) begin
                        duty_d  = up_next;
                        presc_d = '0;
                        if (up_next == target_duty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                DOWN: begin
                    if (target_duty == duty_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (target_duty > duty_q) begin
                        state_d = UP;
                        presc_d = '0;
                    end else if (tick) begin
                        duty_d  = dn_next;
                        presc_d = '0;
                        if (dn_next == target_duty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ramping_d = state_d != IDLE;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            ramping_q <= ramping_d;
        end
    end

    assign duty_out = duty_q;
    assign ramping  = ramping_q;
    assign done     = done_q;
endmodule

// File: tb/tb_pwm_duty_ramper.sv
// tb_pwm_duty_ramper: directed and randomized checks against a behavioural ramp model
module tb_pwm_duty_ramper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [7:0]  target_duty = '0;
    logic [3:0]  step = 4'd1;
    logic [15:0] rate_div = '0;
    logic [7:0]  duty_out;
    logic        ramping;
    logic        done;

    int checks = 0;
    int errors = 0;
    int m_duty = 0;
    int m_dir = 0;
    int m_cnt = 0;
    int m_done = 0;

    pwm_duty_ramper dut (
        .clk(clk), .rst(rst), .target_duty(target_duty), .step(step),
        .rate_div(rate_div), .hold(hold), .duty_out(duty_out),
        .ramping(ramping), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: duty approaches target by at most step every rate_div+1 cycles of ramping
    task automatic model_edge();
        int t, want;
        t = int'(target_duty);
        m_done = 0;
        if (rst) begin
            m_duty = 0;
            m_dir = 0;
            m_cnt = 0;
        end else if (hold) begin
            m_done = 0;
        end else if (step == 0) begin
            m_duty = t;
            m_dir = 0;
            m_cnt = 0;
        end else begin
            want = (t > m_duty) ? 1 : (t < m_duty) ? -1 : 0;
            if (m_dir == 0) begin
                if (want != 0) begin
                    m_dir = want;
                    m_cnt = 0;
                end
            end else if (want == 0) begin
                m_dir = 0;
                m_done = 1;
            end else if (want != m_dir) begin
                m_dir = want;
                m_cnt = 0;
            end else if (m_cnt >= int'(rate_div)) begin
                if (m_dir > 0) m_duty = (m_duty + int'(step) > t) ? t : m_duty + int'(step);
                else m_duty = (m_duty - int'(step) < t) ? t : m_duty - int'(step);
                m_cnt = 0;
                if (m_duty == t) begin
                    m_dir = 0;
                    m_done = 1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check("duty_out", duty_out, m_duty);
            check("ramping", ramping, m_dir != 0);
            check("done", done, m_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc(2);
        check("reset_duty", duty_out, 0);
        rst = 1'b0;
        target_duty = 8'd0;
        cyc(10);
        check("idle_duty", duty_out, 0);

        step = 4'd10;
        rate_div = 16'd3;
        target_duty = 8'd100;
        cyc(1);
        check("up_entry", ramping, 1);
        cyc(3);
        check("before_first_step", duty_out, 0);
        cyc(1);
        check("first_step", duty_out, 10);
        cyc(36);
        check("ramp_end", duty_out, 100);
        check("ramp_done", done, 1);
        check("ramp_ramping", ramping, 0);
        cyc(1);
        check("done_one_cycle", done, 0);

        step = 4'd0;
        target_duty = 8'd250;
        cyc(1);
        step = 4'd15;
        rate_div = 16'd0;
        target_duty = 8'd255;
        cyc(2);
        check("sat_up", duty_out, 255);
        check("sat_up_done", done, 1);
        step = 4'd0;
        target_duty = 8'd5;
        cyc(1);
        step = 4'd15;
        target_duty = 8'd0;
        cyc(2);
        check("sat_down", duty_out, 0);
        check("sat_down_done", done, 1);

        step = 4'd10;
        rate_div = 16'd3;
        target_duty = 8'd100;
        cyc(25);
        check("rev_start", duty_out, 60);
        target_duty = 8'd20;
        cyc(1);
        check("rev_no_step", duty_out, 60);
        cyc(4);
        check("rev_first", duty_out, 50);
        cyc(12);
        check("rev_end", duty_out, 20);
        check("rev_done", done, 1);

        step = 4'd0;
        target_duty = 8'd200;
        cyc(1);
        check("bypass", duty_out, 200);
        cyc(3);

        step = 4'd5;
        rate_div = 16'd2;
        target_duty = 8'd150;
        cyc(5);
        hold = 1'b1;
        cyc(20);
        check("hold_duty", duty_out, 195);
        hold = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_ramp", duty_out, 0);
        check("rst_no_done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) target_duty = 8'($urandom);
            if ($urandom_range(0, 4) == 0) step = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0) rate_div = 16'($urandom_range(0, 5));
            hold = $urandom_range(0, 9) == 0;
            rst = $urandom_range(0, 49) == 0;
            cyc($urandom_range(1, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
